fsm_core: RTL and testbench



---
 rtl/fsm_core_pkg.sv | 16 +
 rtl/fsm_core.sv | 64 ++++++
 tb/tb_fsm_core.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fsm_core_pkg.sv
// rtl/fsm_core_pkg.sv - state encodings and command codes for the run-control FSM
package fsm_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STOP  = 2'b10,
        FAULT = 2'b11
    } state_t;

    localparam logic [1:0] CMD_HALT  = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_FAULT = 2'b11;

endpackage

// File: rtl/fsm_core.sv
// rtl/fsm_core.sv - IDLE/RUN/STOP run-control FSM with sticky FAULT and timed clear
module fsm_core
    import fsm_core_pkg::*;
#(
    parameter int FAULT_CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] in_signal,
    output logic [1:0] out_signal
);

    localparam int CW = $clog2(FAULT_CLEAR_CYCLES + 1);
    localparam logic [CW-1:0] CLEAR_LAST = CW'(FAULT_CLEAR_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] clr_cnt;
    logic [CW-1:0] clr_cnt_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = '0;
        case (state)
            IDLE: begin
                if (in_signal == CMD_FAULT)      state_nxt = FAULT;
                else if (in_signal == CMD_START) state_nxt = RUN;
            end
            RUN: begin
                if (in_signal == CMD_FAULT)     state_nxt = FAULT;
                else if (in_signal == CMD_STOP) state_nxt = STOP;
            end
            STOP: begin
                if (in_signal == CMD_FAULT)     state_nxt = FAULT;
                else if (in_signal == CMD_HALT) state_nxt = IDLE;
            end
            FAULT: begin
                // This edge's HALT is the Nth in a row when the count already holds N-1.
                if (in_signal == CMD_HALT) begin
                    if (clr_cnt >= CLEAR_LAST) begin
                        state_nxt   = IDLE;
                        clr_cnt_nxt = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign out_signal = state;

endmodule

// File: tb/tb_fsm_core.sv
// tb/tb_fsm_core.sv - table-driven scoreboard bench for fsm_core
module tb_fsm_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] in_signal = 2'b00;
    logic [1:0] out_signal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] cmd;
        logic [1:0] exp;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [1:0] exp_q[$];
    string      name_q[$];

    fsm_core #(.FAULT_CLEAR_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_signal  (in_signal),
        .out_signal (out_signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: out_signal=%b expected=%b", name, act, exp);
        end
    endtask

    // drive a command just after an edge, expect the result one edge later
    task automatic step(input logic [1:0] cmd, input logic [1:0] exp, input string name);
        logic [1:0] e;
        string      n;
        in_signal = cmd;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, out_signal, e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: out_signal=%b expected=finish", out_signal);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs.push_back('{2'b10, 2'b00, "idle_hold_stop"});
        vecs.push_back('{2'b01, 2'b01, "idle_to_run"});
        vecs.push_back('{2'b00, 2'b01, "run_hold_halt"});
        vecs.push_back('{2'b01, 2'b01, "run_hold_start"});
        vecs.push_back('{2'b10, 2'b10, "run_to_stop"});
        vecs.push_back('{2'b01, 2'b10, "stop_hold_start"});
        vecs.push_back('{2'b10, 2'b10, "stop_hold_stop"});
        vecs.push_back('{2'b00, 2'b00, "stop_to_idle"});
        vecs.push_back('{2'b11, 2'b11, "prio_idle"});
        vecs.push_back('{2'b00, 2'b11, "fault_halt1"});
        vecs.push_back('{2'b00, 2'b00, "fault_clear"});
        vecs.push_back('{2'b01, 2'b01, "idle_to_run2"});
        vecs.push_back('{2'b11, 2'b11, "prio_run"});
        vecs.push_back('{2'b00, 2'b11, "fault_halt1b"});
        vecs.push_back('{2'b01, 2'b11, "fault_restart"});
        vecs.push_back('{2'b00, 2'b11, "fault_halt1c"});
        vecs.push_back('{2'b00, 2'b00, "fault_clear2"});
        vecs.push_back('{2'b01, 2'b01, "idle_to_run3"});
        vecs.push_back('{2'b10, 2'b10, "run_to_stop2"});
        vecs.push_back('{2'b11, 2'b11, "prio_stop"});
        vecs.push_back('{2'b10, 2'b11, "fault_hold_stop"});
        vecs.push_back('{2'b11, 2'b11, "fault_hold_fault"});
        vecs.push_back('{2'b00, 2'b11, "fault_halt1d"});
        vecs.push_back('{2'b00, 2'b00, "fault_clear3"});
        vecs.push_back('{2'b00, 2'b00, "idle_hold_halt"});

        // reset held across edges with HALT applied
        reset = 1'b1;
        in_signal = 2'b00;
        #1;
        check("reset_async", out_signal, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", out_signal, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_release", out_signal, 2'b00);

        foreach (vecs[i]) step(vecs[i].cmd, vecs[i].exp, vecs[i].name);

        // asynchronous reset between edges while in RUN
        step(2'b01, 2'b01, "pre_async_run");
        #2;
        reset = 1'b1;
        #1;
        check("async_mid_run", out_signal, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        step(2'b00, 2'b00, "post_async_idle");
        step(2'b01, 2'b01, "post_async_start");

        // reset during FAULT must also clear the count
        step(2'b11, 2'b11, "fault_again");
        step(2'b00, 2'b11, "fault_partial");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_in_fault", out_signal, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        step(2'b11, 2'b11, "fault_after_reset");
        step(2'b00, 2'b11, "count_was_cleared");
        step(2'b00, 2'b00, "fault_clear4");

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
